// File: rtl/serial_rcs_subtractor.sv
// Bit-serial ripple-borrow subtractor: D = A - B - Bin, one bit per clock, LSB first.
// Operands enter on an in_valid/in_ready handshake; the result leaves on out_valid/out_ready.
// Optional macro RCS_OVERFLOW_FLAG_EN adds the signed-overflow output V.
module serial_rcs_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef RCS_OVERFLOW_FLAG_EN
    ,
    output logic             V
`endif
);

    // One extra bit so the counter never wraps, even for WIDTH=1
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             bout_q, bout_d;
    logic             valid_q, valid_d;
    logic             v_q, v_d;

    logic             d_bit;
    logic             borrow_nx;
    logic [WIDTH-1:0] res_nx;

    // Full-subtractor cell and result shift, evaluated on the current LSBs
    always_comb begin
        d_bit     = a_q[0] ^ b_q[0] ^ borrow_q;
        borrow_nx = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
        res_nx    = res_q >> 1;
        res_nx[WIDTH-1] = d_bit;
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        dout_d   = dout_q;
        bout_d   = bout_q;
        valid_d  = valid_q;
        v_d      = v_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = Bin;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                borrow_d = borrow_nx;
                res_d    = res_nx;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = StDone;
                    valid_d = 1'b1;
                    dout_d  = res_nx;
                    bout_d  = borrow_nx;
                    // On the last cycle the LSBs of the shift registers are the operand MSBs
                    v_d     = (a_q[0] ^ b_q[0]) & (a_q[0] ^ d_bit);
                end
            end
            StDone: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
            dout_q   <= '0;
            bout_q   <= 1'b0;
            valid_q  <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            dout_q   <= dout_d;
            bout_q   <= bout_d;
            valid_q  <= valid_d;
            v_q      <= v_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = valid_q;
    assign D         = dout_q;
    assign Bout      = bout_q;
`ifdef RCS_OVERFLOW_FLAG_EN
    assign V         = v_q;
`else
    logic unused_v;
    assign unused_v = v_q;
`endif

endmodule

// File: tb/tb_serial_rcs_subtractor.sv
// Directed self-checking bench for serial_rcs_subtractor (WIDTH=4).
module tb_serial_rcs_subtractor;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] D;
    logic         Bout;
`ifdef RCS_OVERFLOW_FLAG_EN
    logic         V;
`endif

    int n_cmp = 0;
    int n_err = 0;

    serial_rcs_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout)
`ifdef RCS_OVERFLOW_FLAG_EN
        ,
        .V         (V)
`endif
    );

    always #5 clk = ~clk;

    // Present operands for one edge (accept edge), leave at the negedge after it
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        @(negedge clk);
        A = a; B = b; Bin = bin; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid is registered high (bounded)
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (D !== 4'h0) begin n_err++; $display("FAIL rst_d: got %h want 0", D); end
        n_cmp++; if (Bout !== 1'b0) begin n_err++; $display("FAIL rst_bout: got %b want 0", Bout); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        int n;
        start_op(4'b0101, 4'b0011, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (D !== 4'h0) begin n_err++; $display("FAIL midrst_d: got %h want 0", D); end
        n_cmp++; if (Bout !== 1'b0) begin n_err++; $display("FAIL midrst_bout: got %b want 0", Bout); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        start_op(4'b0101, 4'b0011, 1'b1);
        wait_valid(n);
        // Registered at the 4th edge after accept, so first sampled at edge 5
        n_cmp++; if (n !== 4) begin n_err++; $display("FAIL rst_op_latency: got %0d want 4", n); end
        n_cmp++; if (D !== 4'b0001) begin n_err++; $display("FAIL rst_op_d: got %b want 0001", D); end
        n_cmp++; if (Bout !== 1'b0) begin n_err++; $display("FAIL rst_op_bout: got %b want 0", Bout); end
        consume();
    endtask

    task automatic test_borrow_in();
        int n;
        start_op(4'b0000, 4'b0000, 1'b1);
        wait_valid(n);
        n_cmp++; if (D !== 4'b1111) begin n_err++; $display("FAIL bin_zero_d: got %b want 1111", D); end
        n_cmp++; if (Bout !== 1'b1) begin n_err++; $display("FAIL bin_zero_bout: got %b want 1", Bout); end
        consume();
        start_op(4'b1001, 4'b0110, 1'b0);
        wait_valid(n);
        n_cmp++; if (D !== 4'b0011) begin n_err++; $display("FAIL sub_9_6_d: got %b want 0011", D); end
        n_cmp++; if (Bout !== 1'b0) begin n_err++; $display("FAIL sub_9_6_bout: got %b want 0", Bout); end
        consume();
    endtask

    task automatic test_wrap();
        int n;
        start_op(4'b0001, 4'b1111, 1'b0);
        wait_valid(n);
        n_cmp++; if (D !== 4'b0010) begin n_err++; $display("FAIL wrap_1_15_d: got %b want 0010", D); end
        n_cmp++; if (Bout !== 1'b1) begin n_err++; $display("FAIL wrap_1_15_bout: got %b want 1", Bout); end
        consume();
        start_op(4'b1111, 4'b1111, 1'b0);
        wait_valid(n);
        n_cmp++; if (D !== 4'b0000) begin n_err++; $display("FAIL wrap_15_15_d: got %b want 0000", D); end
        n_cmp++; if (Bout !== 1'b0) begin n_err++; $display("FAIL wrap_15_15_bout: got %b want 0", Bout); end
        consume();
    endtask

    task automatic test_back_pressure();
        int n;
        start_op(4'd7, 4'd2, 1'b0);
        wait_valid(n);
        for (int k = 0; k < 7; k++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid[%0d]: got %b want 1", k, out_valid); end
            n_cmp++; if (D !== 4'd5) begin n_err++; $display("FAIL bp_d[%0d]: got %h want 5", k, D); end
            n_cmp++; if (Bout !== 1'b0) begin n_err++; $display("FAIL bp_bout[%0d]: got %b want 0", k, Bout); end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, in_ready); end
            A = 4'hF; B = 4'h0; Bin = 1'b1;
            in_valid = k[0];
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (D !== 4'd5) begin n_err++; $display("FAIL bp_hold_d: got %h want 5", D); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] op_a [3];
        logic [W-1:0] op_b [3];
        logic         op_c [3];
        logic [W-1:0] exp_d [3];
        logic         exp_bo [3];
        int           rise [3];
        int           got;
        int           t;
        op_a[0] = 4'd6; op_b[0] = 4'd1; op_c[0] = 1'b0; exp_d[0] = 4'd5;  exp_bo[0] = 1'b0;
        op_a[1] = 4'd3; op_b[1] = 4'd5; op_c[1] = 1'b0; exp_d[1] = 4'hE;  exp_bo[1] = 1'b1;
        op_a[2] = 4'd8; op_b[2] = 4'd8; op_c[2] = 1'b1; exp_d[2] = 4'hF;  exp_bo[2] = 1'b1;
        got = 0;
        t = 0;
        @(negedge clk);
        A = op_a[0]; B = op_b[0]; Bin = op_c[0];
        in_valid = 1'b1;
        out_ready = 1'b1;
        while (got < 3 && t < 60) begin
            @(negedge clk);
            t++;
            if (out_valid) begin
                rise[got] = t;
                n_cmp++; if (D !== exp_d[got]) begin n_err++; $display("FAIL b2b_d[%0d]: got %h want %h", got, D, exp_d[got]); end
                n_cmp++; if (Bout !== exp_bo[got]) begin n_err++; $display("FAIL b2b_bout[%0d]: got %b want %b", got, Bout, exp_bo[got]); end
                got++;
                if (got < 3) begin
                    A = op_a[got]; B = op_b[got]; Bin = op_c[got];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        n_cmp++; if (got !== 3) begin n_err++; $display("FAIL b2b_count: got %0d want 3", got); end
        if (got == 3) begin
            n_cmp++; if (rise[1] - rise[0] !== W + 2) begin n_err++; $display("FAIL b2b_gap01: got %0d want %0d", rise[1] - rise[0], W + 2); end
            n_cmp++; if (rise[2] - rise[1] !== W + 2) begin n_err++; $display("FAIL b2b_gap12: got %0d want %0d", rise[2] - rise[1], W + 2); end
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_idle: got %b want 1", in_ready); end
    endtask

`ifdef RCS_OVERFLOW_FLAG_EN
    task automatic test_overflow();
        int n;
        start_op(4'b0111, 4'b1111, 1'b0);
        wait_valid(n);
        n_cmp++; if (D !== 4'b1000) begin n_err++; $display("FAIL ovf_d: got %b want 1000", D); end
        n_cmp++; if (Bout !== 1'b1) begin n_err++; $display("FAIL ovf_bout: got %b want 1", Bout); end
        n_cmp++; if (V !== 1'b1) begin n_err++; $display("FAIL ovf_v: got %b want 1", V); end
        consume();
        start_op(4'b0101, 4'b0011, 1'b0);
        wait_valid(n);
        n_cmp++; if (D !== 4'b0010) begin n_err++; $display("FAIL noovf_d: got %b want 0010", D); end
        n_cmp++; if (V !== 1'b0) begin n_err++; $display("FAIL noovf_v: got %b want 0", V); end
        consume();
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_run();
        test_borrow_in();
        test_wrap();
        test_back_pressure();
        test_back_to_back();
`ifdef RCS_OVERFLOW_FLAG_EN
        test_overflow();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
